// File: rtl/arb_client.sv
`default_nettype none
// ============================================================================
// Module   : arb_client
// Purpose  : Requester-side agent for the three-way fixed-priority arbiter.
//            Takes a burst command, requests the bus, issues beats while the
//            grant is held, then releases and waits for the grant to clear.
// Revision : 1.0  initial release
// ============================================================================
module arb_client #(
    parameter int LEN_W    = 4,
    parameter int WAIT_MAX = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             cmd_valid,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             cmd_ready,
    input  logic             gnt,
    output logic             req,
    output logic             beat_valid,
    output logic [LEN_W-1:0] beat_idx,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic             err
);

    localparam logic [7:0] c_WAIT_LAST = 8'(WAIT_MAX - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_XFER = 2'd2,
        S_REL  = 2'd3
    } state_t;

    state_t           r_state,    w_state_next;
    logic [LEN_W-1:0] r_len,      w_len_next;
    logic [LEN_W-1:0] r_beat_idx, w_beat_idx_next;
    logic [7:0]       r_wait,     w_wait_next;
    logic             r_rel_ok,   w_rel_ok_next;
    logic             r_done,     w_done_next;
    logic             r_timeout,  w_timeout_next;
    logic             r_err,      w_err_next;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_len      <= '0;
            r_beat_idx <= '0;
            r_wait     <= '0;
            r_rel_ok   <= 1'b0;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_len      <= w_len_next;
            r_beat_idx <= w_beat_idx_next;
            r_wait     <= w_wait_next;
            r_rel_ok   <= w_rel_ok_next;
            r_done     <= w_done_next;
            r_timeout  <= w_timeout_next;
            r_err      <= w_err_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_len_next      = r_len;
        w_beat_idx_next = r_beat_idx;
        w_wait_next     = r_wait;
        w_rel_ok_next   = r_rel_ok;
        w_done_next     = 1'b0;
        w_timeout_next  = 1'b0;
        w_err_next      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_len_next   = cmd_len;
                    w_wait_next  = '0;
                    w_state_next = S_REQ;
                end
            end
            S_REQ: begin
                // A grant landing on the final wait cycle still wins.
                if (gnt) begin
                    w_beat_idx_next = '0;
                    w_state_next    = S_XFER;
                end else if (r_wait == c_WAIT_LAST) begin
                    w_timeout_next = 1'b1;
                    w_state_next   = S_IDLE;
                end else begin
                    w_wait_next = r_wait + 8'd1;
                end
            end
            S_XFER: begin
                if (!gnt) begin
                    w_err_next    = 1'b1;
                    w_rel_ok_next = 1'b0;
                    w_state_next  = S_REL;
                end else if (r_beat_idx == r_len) begin
                    w_rel_ok_next = 1'b1;
                    w_state_next  = S_REL;
                end else begin
                    w_beat_idx_next = r_beat_idx + 1'b1;
                end
            end
            S_REL: begin
                // Stays here while the grant is stuck high.
                if (!gnt) begin
                    w_done_next  = r_rel_ok;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign cmd_ready  = (r_state == S_IDLE);
    assign req        = (r_state == S_REQ) || (r_state == S_XFER);
    assign beat_valid = (r_state == S_XFER);
    assign beat_idx   = beat_valid ? r_beat_idx : '0;
    assign busy       = (r_state != S_IDLE);
    assign done       = r_done;
    assign timeout    = r_timeout;
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_arb_client.sv
`default_nettype none
// ============================================================================
// Module   : tb_arb_client
// Purpose  : Directed self-checking bench for arb_client, single and 3-port.
// Revision : 1.0  initial release
// ============================================================================
module tb_arb_client;

    logic       clk = 1'b0;
    logic       resetn;
    logic       cmd_valid;
    logic [3:0] cmd_len;
    logic       cmd_ready, gnt, req, beat_valid, busy, done, timeout, err;
    logic [3:0] beat_idx;
    logic       man_en, man_gnt;
    logic       arb_g = 1'b0;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Registered single-port arbiter, or a manually forced grant.
    always @(posedge clk) arb_g <= req;
    assign gnt = man_en ? man_gnt : arb_g;

    arb_client #(.LEN_W(4), .WAIT_MAX(8)) dut (
        .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_len(cmd_len),
        .cmd_ready(cmd_ready), .gnt(gnt), .req(req), .beat_valid(beat_valid),
        .beat_idx(beat_idx), .busy(busy), .done(done), .timeout(timeout), .err(err)
    );

    // Three clients behind a registered fixed-priority arbiter.
    logic [2:0] m_valid = 3'b000;
    logic [3:0] m_len [3];
    logic [2:0] m_ready, m_req, m_bv, m_busy, m_done, m_to, m_err;
    logic [2:0] m_gnt = 3'b000;
    logic [3:0] m_idx [3];

    always @(posedge clk) begin
        if      (m_req[0]) m_gnt <= 3'b001;
        else if (m_req[1]) m_gnt <= 3'b010;
        else if (m_req[2]) m_gnt <= 3'b100;
        else               m_gnt <= 3'b000;
    end

    for (genvar p = 0; p < 3; p++) begin : g_port
        arb_client #(.LEN_W(4), .WAIT_MAX(40)) u_client (
            .clk(clk), .resetn(resetn), .cmd_valid(m_valid[p]), .cmd_len(m_len[p]),
            .cmd_ready(m_ready[p]), .gnt(m_gnt[p]), .req(m_req[p]), .beat_valid(m_bv[p]),
            .beat_idx(m_idx[p]), .busy(m_busy[p]), .done(m_done[p]), .timeout(m_to[p]),
            .err(m_err[p])
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; cmd_valid = 1'b0; cmd_len = '0; man_en = 1'b0; man_gnt = 1'b0;
        m_len[0] = 4'd2; m_len[1] = 4'd1; m_len[2] = 4'd3;
        #1;
        vectors++;
        if ({cmd_ready, req, beat_valid, busy, done, timeout, err} !== 7'b1000000) begin
            miscompares++;
            $display("FAIL reset_flags: got %b want 1000000",
                     {cmd_ready, req, beat_valid, busy, done, timeout, err});
        end
        vectors++;
        if (beat_idx !== 4'd0) begin miscompares++; $display("FAIL reset_idx: got %0d want 0", beat_idx); end
        tick(); tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_burst();
        cmd_len = 4'd3; cmd_valid = 1'b1;
        vectors++;
        if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL burst_ready: got %b want 1", cmd_ready); end
        tick();
        cmd_valid = 1'b0;
        vectors++;
        if ({req, busy, cmd_ready, beat_valid} !== 4'b1100) begin
            miscompares++; $display("FAIL burst_req_k1: got %b want 1100", {req, busy, cmd_ready, beat_valid});
        end
        tick();
        vectors++;
        if ({req, beat_valid} !== 2'b10) begin miscompares++; $display("FAIL burst_wait: got %b want 10", {req, beat_valid}); end
        tick();
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (beat_valid !== 1'b1 || beat_idx !== 4'(i)) begin
                miscompares++; $display("FAIL burst_beat%0d: got bv=%b idx=%0d want bv=1 idx=%0d", i, beat_valid, beat_idx, i);
            end
            tick();
        end
        vectors++;
        if ({req, beat_valid, busy, done} !== 4'b0010) begin
            miscompares++; $display("FAIL burst_rel: got %b want 0010", {req, beat_valid, busy, done});
        end
        tick();
        vectors++;
        if ({busy, done} !== 2'b10) begin miscompares++; $display("FAIL burst_rel2: got %b want 10", {busy, done}); end
        tick();
        vectors++;
        if ({done, cmd_ready, busy} !== 3'b110) begin
            miscompares++; $display("FAIL burst_done: got %b want 110", {done, cmd_ready, busy});
        end
        tick();
        vectors++;
        if ({done, busy} !== 2'b00) begin miscompares++; $display("FAIL burst_after: got %b want 00", {done, busy}); end
    endtask

    task automatic test_timeout();
        int n = 0;
        int bv_seen = 0;
        man_en = 1'b1; man_gnt = 1'b0;
        cmd_len = 4'd2; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 20 && req; i++) begin
            if (beat_valid) bv_seen++;
            n++;
            tick();
        end
        vectors++;
        if (n !== 8) begin miscompares++; $display("FAIL to_req_cycles: got %0d want 8", n); end
        vectors++;
        if ({timeout, cmd_ready, busy} !== 3'b110) begin
            miscompares++; $display("FAIL to_pulse: got %b want 110", {timeout, cmd_ready, busy});
        end
        tick();
        vectors++;
        if (timeout !== 1'b0 || bv_seen !== 0) begin
            miscompares++; $display("FAIL to_after: got to=%b beats=%0d want 0 0", timeout, bv_seen);
        end
    endtask

    task automatic test_late_grant();
        int bad = 0;
        man_en = 1'b1; man_gnt = 1'b0;
        cmd_len = 4'd1; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (req !== 1'b1 || timeout !== 1'b0) bad++;
            tick();
        end
        man_gnt = 1'b1;
        tick();
        vectors++;
        if ({beat_valid, timeout, bad[3:0]} !== 6'b100000) begin
            miscompares++; $display("FAIL late_xfer: got bv=%b to=%b bad=%0d want 1 0 0", beat_valid, timeout, bad);
        end
        tick();
        vectors++;
        if (beat_idx !== 4'd1) begin miscompares++; $display("FAIL late_idx: got %0d want 1", beat_idx); end
        tick();
        man_gnt = 1'b0;
        tick();
        vectors++;
        if ({done, timeout, busy} !== 3'b100) begin
            miscompares++; $display("FAIL late_done: got %b want 100", {done, timeout, busy});
        end
    endtask

    task automatic test_grant_loss();
        int beats = 0;
        int err_seen = 0;
        int done_seen = 0;
        man_en = 1'b1; man_gnt = 1'b0;
        cmd_len = 4'd5; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0; man_gnt = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            if (beat_valid) beats++;
            if (i == 1) man_gnt = 1'b0;
            tick();
        end
        vectors++;
        if ({err, req, beat_valid} !== 3'b100) begin
            miscompares++; $display("FAIL loss_err: got %b want 100", {err, req, beat_valid});
        end
        for (int i = 0; i < 4; i++) begin
            if (beat_valid) beats++;
            if (err) err_seen++;
            if (done) done_seen++;
            tick();
        end
        vectors++;
        if (beats !== 2 || err_seen !== 1 || done_seen !== 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL loss_summary: got beats=%0d err=%0d done=%0d busy=%b want 2 1 0 0", beats, err_seen, done_seen, busy);
        end
    endtask

    task automatic test_async_reset();
        int beats = 0;
        int done_seen = 0;
        man_en = 1'b0;
        cmd_len = 4'd7; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick(); tick(); tick();
        vectors++;
        if (beat_valid !== 1'b1) begin miscompares++; $display("FAIL arst_pre: got bv=%b want 1", beat_valid); end
        #2 resetn = 1'b0;
        #1;
        vectors++;
        if ({req, beat_valid, busy} !== 3'b000) begin
            miscompares++; $display("FAIL arst_async: got %b want 000", {req, beat_valid, busy});
        end
        tick(); tick();
        resetn = 1'b1;
        tick();
        cmd_len = 4'd0; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (beat_valid) beats++;
            if (done) done_seen++;
            tick();
        end
        vectors++;
        if (beats !== 1 || done_seen !== 1 || busy !== 1'b0) begin
            miscompares++; $display("FAIL arst_burst: got beats=%0d done=%0d busy=%b want 1 1 0", beats, done_seen, busy);
        end
    endtask

    task automatic test_three_way();
        int first [3];
        int dones [3];
        int overlap = 0;
        int tos = 0;
        for (int p = 0; p < 3; p++) begin first[p] = -1; dones[p] = 0; end
        vectors++;
        if (m_ready !== 3'b111) begin miscompares++; $display("FAIL tri_ready: got %b want 111", m_ready); end
        m_valid = 3'b111;
        tick();
        m_valid = 3'b000;
        for (int t = 0; t < 200; t++) begin
            if ($countones(m_bv) > 1) overlap++;
            tos += $countones(m_to | m_err);
            for (int p = 0; p < 3; p++) begin
                if (m_bv[p] && first[p] < 0) first[p] = t;
                if (m_done[p]) dones[p]++;
            end
            if (dones[0] + dones[1] + dones[2] >= 3 && m_busy == 3'b000) break;
            tick();
        end
        vectors++;
        if (overlap !== 0 || tos !== 0) begin
            miscompares++; $display("FAIL tri_overlap: got overlap=%0d to/err=%0d want 0 0", overlap, tos);
        end
        vectors++;
        if (first[0] < 0 || first[1] <= first[0] || first[2] <= first[1]) begin
            miscompares++; $display("FAIL tri_order: got %0d %0d %0d want increasing", first[0], first[1], first[2]);
        end
        vectors++;
        if (dones[0] !== 1 || dones[1] !== 1 || dones[2] !== 1) begin
            miscompares++; $display("FAIL tri_done: got %0d %0d %0d want 1 1 1", dones[0], dones[1], dones[2]);
        end
    endtask

    initial begin
        test_reset();
        test_burst();
        test_timeout();
        test_late_grant();
        test_grant_loss();
        test_async_reset();
        test_three_way();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
